// File: rtl/fetch_stage.sv
// fetch_stage: PC register, imem address and IF/ID pipeline register.
// Optional ebreak halt enabled with FETCH_HALT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic [31:0] fetch_cnt,
    output logic        halted
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        deliver;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    // a real word enters IF/ID this edge
    assign deliver   = !redirect_valid && !stall && !halted;

`ifdef FETCH_HALT_EN
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    logic halt_q;
    assign halted = halt_q;

    // set on latching ebreak, cleared by a redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            halt_q <= 1'b0;
        else if (redirect_valid)
            halt_q <= 1'b0;
        else if (deliver && imem_rdata == EBREAK)
            halt_q <= 1'b1;
    end
`else
    assign halted = 1'b0;
`endif

    // PC: redirect > halt/stall hold > sequential
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= RESET_PC;
        else if (redirect_valid)
            pc <= {redirect_pc[31:2], 2'b00};
        else if (!halted && !stall)
            pc <= pc_plus4;
    end

    // IF/ID: flush on redirect, hold on stall, bubble on halt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_inst  <= NOP_INST;
            if_id_pc    <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (redirect_valid) begin
            if_id_inst  <= NOP_INST;
            if_id_pc    <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (stall) begin
            if_id_valid <= if_id_valid;
        end else if (halted) begin
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
        end else begin
            if_id_inst  <= imem_rdata;
            if_id_pc    <= pc;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
        end
    end

    // count delivered instructions, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fetch_cnt <= 32'd0;
        else if (deliver)
            fetch_cnt <= fetch_cnt + 32'd1;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage.
// ROM returns {addr[15:0],16'h1234}, ebreak at 0x3010.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic [31:0] fetch_cnt;
    logic        halted;

    int n_run  = 0;
    int n_fail = 0;

`ifdef FETCH_HALT_EN
    localparam logic [31:0] CB = 32'd5;
    localparam logic        HE = 1'b1;
`else
    localparam logic [31:0] CB = 32'd6;
    localparam logic        HE = 1'b0;
`endif

    fetch_stage dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .if_id_pc(if_id_pc),
        .if_id_pc4(if_id_pc4),
        .if_id_inst(if_id_inst),
        .if_id_valid(if_id_valid),
        .fetch_cnt(fetch_cnt),
        .halted(halted)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (imem_addr == 32'h0000_3010)
            imem_rdata = 32'h0010_0073;
        else
            imem_rdata = {imem_addr[15:0], 16'h1234};
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        step();
        check("rst_addr", imem_addr, 32'h3000);
        check("rst_inst", if_id_inst, 32'h13);
        check("rst_pc", if_id_pc, 32'h0);
        check("rst_pc4", if_id_pc4, 32'h0);
        check("rst_valid", {31'd0, if_id_valid}, 32'd0);
        check("rst_cnt", fetch_cnt, 32'd0);
        check("rst_halt", {31'd0, halted}, 32'd0);
        rst = 1'b0;
        #1;
        check("c0_addr", imem_addr, 32'h3000);
        step();
        check("e1_addr", imem_addr, 32'h3004);
        check("e1_inst", if_id_inst, 32'h3000_1234);
        step();
        check("e2_addr", imem_addr, 32'h3008);
        check("e2_pc", if_id_pc, 32'h3004);
        check("e2_pc4", if_id_pc4, 32'h3008);
        check("e2_valid", {31'd0, if_id_valid}, 32'd1);
        check("e2_cnt", fetch_cnt, 32'd2);
        // stall two edges
        stall = 1'b1;
        step();
        step();
        check("st_addr", imem_addr, 32'h3008);
        check("st_pc", if_id_pc, 32'h3004);
        check("st_inst", if_id_inst, 32'h3004_1234);
        check("st_cnt", fetch_cnt, 32'd2);
        stall = 1'b0;
        step();
        check("un_addr", imem_addr, 32'h300C);
        check("un_pc", if_id_pc, 32'h3008);
        check("un_cnt", fetch_cnt, 32'd3);
        step();
        step();
        check("eb_inst", if_id_inst, 32'h0010_0073);
        check("eb_addr", imem_addr, 32'h3014);
        check("eb_halt", {31'd0, halted}, {31'd0, HE});
        step();
        check("h_addr", imem_addr, HE ? 32'h3014 : 32'h3018);
        check("h_valid", {31'd0, if_id_valid}, {31'd0, !HE});
        check("h_cnt", fetch_cnt, CB);
        // redirect, low bits dropped
        redirect_valid = 1'b1;
        redirect_pc = 32'h3043;
        step();
        redirect_valid = 1'b0;
        check("rd_addr", imem_addr, 32'h3040);
        check("rd_inst", if_id_inst, 32'h13);
        check("rd_valid", {31'd0, if_id_valid}, 32'd0);
        check("rd_halt", {31'd0, halted}, 32'd0);
        check("rd_cnt", fetch_cnt, CB);
        step();
        check("rt_inst", if_id_inst, 32'h3040_1234);
        check("rt_pc", if_id_pc, 32'h3040);
        check("rt_valid", {31'd0, if_id_valid}, 32'd1);
        check("rt_cnt", fetch_cnt, CB + 32'd1);
        // redirect and stall together
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h3100;
        step();
        redirect_valid = 1'b0;
        check("rs_addr", imem_addr, 32'h3100);
        check("rs_valid", {31'd0, if_id_valid}, 32'd0);
        check("rs_inst", if_id_inst, 32'h13);
        step();
        check("rs_hold", imem_addr, 32'h3100);
        stall = 1'b0;
        step();
        check("rs_go", imem_addr, 32'h3104);
        check("rs_pc", if_id_pc, 32'h3100);
        check("rs_cnt", fetch_cnt, CB + 32'd2);
        // back-to-back redirects
        redirect_valid = 1'b1;
        redirect_pc = 32'h4000;
        step();
        check("bb1_addr", imem_addr, 32'h4000);
        redirect_pc = 32'h5000;
        step();
        redirect_valid = 1'b0;
        check("bb2_addr", imem_addr, 32'h5000);
        check("bb2_valid", {31'd0, if_id_valid}, 32'd0);
        step();
        check("bb_pc", if_id_pc, 32'h5000);
        check("bb_inst", if_id_inst, 32'h5000_1234);
        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        check("wr_addr", imem_addr, 32'h0);
        check("wr_pc", if_id_pc, 32'hFFFF_FFFC);
        check("wr_pc4", if_id_pc4, 32'h0);
        check("wr_cnt", fetch_cnt, CB + 32'd4);
        // async reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        check("ar_addr", imem_addr, 32'h3000);
        check("ar_valid", {31'd0, if_id_valid}, 32'd0);
        check("ar_cnt", fetch_cnt, 32'd0);
        check("ar_inst", if_id_inst, 32'h13);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
